// File: rtl/bcd_display_scan.sv
// ---------------------------------------------------------------------------
// bcd_display_scan
//
// Two-digit multiplexed 7-segment display driver. It accepts one 8-bit BCD word
// (tens nibble, units nibble) through a valid/ready handshake. The word is
// shown by alternating the units and tens digits on one shared segment bus.
// A zero tens digit is blanked. A nibble above 9 is shown as a dash and
// raises error_bcd.
//
// A new word is accepted only while idle or in the last cycle of a frame.
// This keeps a frame from being torn halfway through.
//
// Parameters:
//   SCAN_DIV     clock cycles each digit stays lit (2..65535)
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   DatoEntrada  BCD word, [7:4] tens, [3:0] units
//   dato_valido  DatoEntrada valid, held by the source until accepted
//   apagar       synchronous blank request, returns the block to REPOSO
//   listo        block accepts a word at the next rising edge
//   segmentos    {g,f,e,d,c,b,a}, active-high
//   anodos       digit enables, active-low, [0] units, [1] tens
//   error_bcd    the latched word contains a nibble greater than 9
//
// Every output is decoded from registered state only. No input reaches an
// output combinationally.
// ---------------------------------------------------------------------------
module bcd_display_scan #(
   parameter int unsigned SCAN_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] DatoEntrada,
   input  logic       dato_valido,
   input  logic       apagar,
   output logic       listo,
   output logic [6:0] segmentos,
   output logic [1:0] anodos,
   output logic       error_bcd
);

   localparam int unsigned    CW       = $clog2(SCAN_DIV);
   localparam logic [CW-1:0]  CNT_LAST = CW'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      REPOSO    = 2'd0,
      MOSTRAR_U = 2'd1,
      MOSTRAR_D = 2'd2
   } estado_t;

   estado_t       estado, estado_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [7:0]    dato_reg;
   logic          cnt_last;
   logic          captura;

   // Digit code. Any non-BCD value is shown as a dash.
   function automatic logic [6:0] decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   // NOTE: sequential state uses non-blocking assignments so that every
   // register samples pre-edge values, whatever order the statements are in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado    <= REPOSO;
         cnt       <= '0;
         dato_reg  <= 8'h00;
         error_bcd <= 1'b0;
      end else begin
         estado <= estado_nx;
         cnt    <= cnt_nx;
         if (captura) begin
            dato_reg  <= DatoEntrada;
            error_bcd <= (DatoEntrada[7:4] > 4'd9) || (DatoEntrada[3:0] > 4'd9);
         end
      end
   end

   assign cnt_last = (cnt == CNT_LAST);

   // NOTE: every signal is given a default at the top of the always_comb, so
   // no branch can leave a value unassigned and infer a latch.
   always_comb begin
      estado_nx = estado;
      cnt_nx    = '0;
      listo     = 1'b0;
      captura   = 1'b0;
      segmentos = 7'h00;
      anodos    = 2'b11;

      // The ready window is the idle state, or the final cycle of the tens
      // phase, which is the frame boundary.
      listo   = (estado == REPOSO) || ((estado == MOSTRAR_D) && cnt_last);
      captura = dato_valido && listo && !apagar;

      // Blanking takes priority over capture. A capture restarts the frame
      // at the units phase.
      if (apagar) begin
         estado_nx = REPOSO;
      end else if (captura) begin
         estado_nx = MOSTRAR_U;
      end else begin
         case (estado)
            MOSTRAR_U: begin
               if (cnt_last) estado_nx = MOSTRAR_D;
               else          cnt_nx    = cnt + CW'(1);
            end
            MOSTRAR_D: begin
               if (cnt_last) estado_nx = MOSTRAR_U;
               else          cnt_nx    = cnt + CW'(1);
            end
            default: estado_nx = REPOSO;
         endcase
      end

      case (estado)
         MOSTRAR_U: begin
            anodos    = 2'b10;
            segmentos = decode(dato_reg[3:0]);
         end
         MOSTRAR_D: begin
            // A leading zero leaves the tens digit dark.
            if (dato_reg[7:4] != 4'd0) begin
               anodos    = 2'b01;
               segmentos = decode(dato_reg[7:4]);
            end
         end
         default: begin
            anodos    = 2'b11;
            segmentos = 7'h00;
         end
      endcase
   end

endmodule

// File: tb/tb_bcd_display_scan.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_scan
//
// Self-checking bench for bcd_display_scan with SCAN_DIV=4. It has three
// parts:
//   - a fixed vector table with hand-derived expected outputs,
//   - hand-written multi-cycle sequences (mid-frame handshake, decoder sweep,
//     blank request against capture, asynchronous reset mid-frame),
//   - a random run checked against a frame-position reference model.
// The model tracks an "active" flag and a position 0..2*SD-1 inside the
// frame. It derives the expected outputs from that position.
// ---------------------------------------------------------------------------
module tb_bcd_display_scan;

   localparam int SD = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] din = 8'h00;
   logic       valid = 1'b0;
   logic       apg = 1'b0;
   logic       listo;
   logic [6:0] seg;
   logic [1:0] an;
   logic       err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bcd_display_scan #(.SCAN_DIV(SD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .DatoEntrada (din),
      .dato_valido (valid),
      .apagar      (apg),
      .listo       (listo),
      .segmentos   (seg),
      .anodos      (an),
      .error_bcd   (err)
   );

   // ---------------- reference model ----------------
   logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   bit         m_active = 1'b0;
   int         m_pos    = 0;
   logic [7:0] m_word   = 8'h00;
   bit         m_err    = 1'b0;
   bit         m_acc    = 1'b0;

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      if (n > 4'd9) return 7'h40;
      return seg_tab[n];
   endfunction

   function automatic bit m_listo();
      return !m_active || (m_pos == 2*SD-1);
   endfunction

   function automatic logic [6:0] m_seg();
      if (!m_active)             return 7'h00;
      if (m_pos < SD)            return seg_of(m_word[3:0]);
      if (m_word[7:4] == 4'd0)   return 7'h00;
      return seg_of(m_word[7:4]);
   endfunction

   function automatic logic [1:0] m_an();
      if (!m_active)             return 2'b11;
      if (m_pos < SD)            return 2'b10;
      if (m_word[7:4] == 4'd0)   return 2'b11;
      return 2'b01;
   endfunction

   task automatic model_step(input logic [7:0] d, input logic v, input logic a);
      m_acc = v && m_listo() && !a;
      if (a) begin
         m_active = 1'b0;
         m_pos    = 0;
      end else if (m_acc) begin
         m_active = 1'b1;
         m_pos    = 0;
         m_word   = d;
         m_err    = (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
      end else if (m_active) begin
         m_pos = (m_pos + 1) % (2*SD);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_pos    = 0;
      m_word   = 8'h00;
      m_err    = 1'b0;
   endtask

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic compare_model(input string tag);
      check({tag, "_seg"},   {9'd0, seg},    {9'd0, m_seg()});
      check({tag, "_an"},    {14'd0, an},    {14'd0, m_an()});
      check({tag, "_listo"}, {15'd0, listo}, {15'd0, m_listo()});
      check({tag, "_err"},   {15'd0, err},   {15'd0, m_err});
   endtask

   // Inputs are driven 1 time unit after a rising edge. The outputs are
   // examined 1 time unit after the following edge.
   task automatic apply(input logic [7:0] d, input logic v, input logic a);
      din   = d;
      valid = v;
      apg   = a;
      @(posedge clk);
      model_step(d, v, a);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] din;
      logic       valid;
      logic       apg;
      logic [6:0] seg;
      logic [1:0] an;
      logic       listo;
      logic       err;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic [7:0] d, input logic v, input logic a,
                      input logic [6:0] s, input logic [1:0] n,
                      input logic l, input logic e);
      vec_t t;
      t.din = d; t.valid = v; t.apg = a;
      t.seg = s; t.an = n; t.listo = l; t.err = e;
      vq.push_back(t);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      bit pend;
      logic [7:0] pw;
      logic [7:0] sweep [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                 8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};

      // Reset values while reset is held.
      #1;
      check("rst_listo", {15'd0, listo}, 16'd1);
      check("rst_an",    {14'd0, an},    16'h3);
      check("rst_seg",   {9'd0, seg},    16'h00);
      check("rst_err",   {15'd0, err},   16'd0);
      #12 rst_n = 1'b1;
      @(posedge clk);
      #1;
      compare_model("idle");

      // Basic scan of 0x15, blank, leading zero, invalid word, held word.
      add(8'h15, 1, 0, 7'h6D, 2'b10, 0, 0);
      for (int i = 0; i < 3; i++) add(8'h00, 0, 0, 7'h6D, 2'b10, 0, 0);
      for (int i = 0; i < 3; i++) add(8'h00, 0, 0, 7'h06, 2'b01, 0, 0);
      add(8'h00, 0, 0, 7'h06, 2'b01, 1, 0);
      add(8'h00, 0, 0, 7'h6D, 2'b10, 0, 0);
      add(8'h00, 0, 1, 7'h00, 2'b11, 1, 0);
      add(8'h07, 1, 0, 7'h07, 2'b10, 0, 0);
      for (int i = 0; i < 3; i++) add(8'h00, 0, 0, 7'h07, 2'b10, 0, 0);
      for (int i = 0; i < 3; i++) add(8'h00, 0, 0, 7'h00, 2'b11, 0, 0);
      add(8'h00, 0, 0, 7'h00, 2'b11, 1, 0);
      add(8'h1A, 1, 0, 7'h40, 2'b10, 0, 1);
      for (int i = 0; i < 3; i++) add(8'h09, 1, 0, 7'h40, 2'b10, 0, 1);
      for (int i = 0; i < 3; i++) add(8'h09, 1, 0, 7'h06, 2'b01, 0, 1);
      add(8'h09, 1, 0, 7'h06, 2'b01, 1, 1);
      add(8'h09, 1, 0, 7'h6F, 2'b10, 0, 0);
      add(8'h00, 0, 0, 7'h6F, 2'b10, 0, 0);

      foreach (vq[i]) begin
         apply(vq[i].din, vq[i].valid, vq[i].apg);
         check($sformatf("vec%0d_seg", i),   {9'd0, seg},    {9'd0, vq[i].seg});
         check($sformatf("vec%0d_an", i),    {14'd0, an},    {14'd0, vq[i].an});
         check($sformatf("vec%0d_listo", i), {15'd0, listo}, {15'd0, vq[i].listo});
         check($sformatf("vec%0d_err", i),   {15'd0, err},   {15'd0, vq[i].err});
      end

      // Mid-frame handshake: 0x12 offered two cycles into the units phase of 0x15.
      apply(8'h00, 0, 1);
      apply(8'h15, 1, 0);
      apply(8'h00, 0, 0);
      apply(8'h00, 0, 0);
      n = 0;
      while (!listo && n < 20) begin
         n++;
         apply(8'h12, 1, 0);
         compare_model("hs_wait");
      end
      check("hs_busy_cycles", 16'(n), 16'd5);
      apply(8'h12, 1, 0);
      check("hs_new_seg", {9'd0, seg}, 16'h5B);
      check("hs_new_an",  {14'd0, an}, 16'h2);
      apply(8'h00, 0, 0);
      check("hs_listo_pulse_end", {15'd0, listo}, 16'd0);

      // Decoder sweep: each word is scanned for one full frame.
      foreach (sweep[i]) begin
         apply(8'h00, 0, 1);
         apply(sweep[i], 1, 0);
         check($sformatf("sweep%0d_units", i), {9'd0, seg}, {9'd0, seg_of(sweep[i][3:0])});
         for (int k = 0; k < 2*SD; k++) begin
            compare_model($sformatf("sweep%0d", i));
            apply(8'h00, 0, 0);
         end
      end

      // Blank request together with an offered word at the frame boundary.
      apply(8'h00, 0, 1);
      apply(8'h1A, 1, 0);
      n = 0;
      while (!listo && n < 40) begin
         n++;
         apply(8'h00, 0, 0);
      end
      check("apg_wait_listo", {15'd0, listo}, 16'd1);
      apply(8'h33, 1, 1);
      check("apg_listo", {15'd0, listo}, 16'd1);
      check("apg_an",    {14'd0, an},    16'h3);
      check("apg_seg",   {9'd0, seg},    16'h00);
      check("apg_err",   {15'd0, err},   16'd1);
      apply(8'h00, 0, 0);
      compare_model("apg_idle");
      apply(8'h21, 1, 0);
      check("apg_after_seg", {9'd0, seg},  16'h06);
      check("apg_after_err", {15'd0, err}, 16'd0);

      // Asynchronous reset asserted in the middle of the tens phase.
      apply(8'h00, 0, 1);
      apply(8'h1A, 1, 0);
      for (int k = 0; k < SD + 1; k++) apply(8'h00, 0, 0);
      check("mid_pre_an", {14'd0, an}, 16'h1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_listo", {15'd0, listo}, 16'd1);
      check("mid_rst_an",    {14'd0, an},    16'h3);
      check("mid_rst_seg",   {9'd0, seg},    16'h00);
      check("mid_rst_err",   {15'd0, err},   16'd0);
      din = 8'h00; valid = 1'b0; apg = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      compare_model("post_rst");

      // Random run. The source holds each word until the model accepts it.
      pend = 1'b0;
      pw   = 8'h00;
      for (int i = 0; i < 400; i++) begin
         logic a;
         if (!pend && $urandom_range(0, 2) == 0) begin
            pend = 1'b1;
            pw   = 8'($urandom);
         end
         a = ($urandom_range(0, 15) == 0);
         apply(pw, pend, a);
         if (m_acc) pend = 1'b0;
         compare_model("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Two-digit multiplexed 7-segment display driver, directly downstream of the 4-bit binary-to-BCD decoder. It accepts the decoder's 8-bit BCD word (tens nibble, units nibble) through a valid/ready handshake and latches it. It then time-multiplexes the two digits onto one shared segment bus with per-digit anode enables. It blanks a leading zero in the tens digit and flags non-BCD nibbles.

## Interface
Parameters:
- SCAN_DIV, default 4: clock cycles each digit stays lit; legal range 2..65535; counter width $clog2(SCAN_DIV).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- DatoEntrada  in  8  BCD word from the decoder; [7:4] tens, [3:0] units.
- dato_valido  in  1  DatoEntrada is valid; held by the source until accepted.
- apagar  in  1  synchronous blank request; returns the block to REPOSO.
- listo  out  1  block can accept a word this cycle.
- segmentos  out  7  {g,f,e,d,c,b,a}, active-high.
- anodos  out  2  digit enables, active-low; [0] units, [1] tens.
- error_bcd  out  1  the latched word has a nibble > 9.

## Operation
- State register with three states:
  - REPOSO: display dark.
  - MOSTRAR_U: units digit lit.
  - MOSTRAR_D: tens digit lit.
- Refresh counter cnt runs 0..SCAN_DIV-1. It clears on every state change and on every capture.
- A capture happens on a rising edge where dato_valido && listo && !apagar.
  - The capture latches DatoEntrada into dato_reg.
  - error_bcd is loaded with (dato[7:4]>9) || (dato[3:0]>9).
  - Next state is MOSTRAR_U with cnt=0.
- listo timing:
  - listo=1 in REPOSO.
  - listo=1 in MOSTRAR_D when cnt==SCAN_DIV-1, a one-cycle frame-boundary window.
  - listo=0 in all other cycles, so a displayed frame is never torn.
- State transitions:
  - MOSTRAR_U with cnt==SCAN_DIV-1 goes to MOSTRAR_D.
  - MOSTRAR_D with cnt==SCAN_DIV-1 and no capture goes to MOSTRAR_U and keeps the old dato_reg.
  - REPOSO with no capture stays in REPOSO.
- apagar=1 at an edge forces REPOSO and cnt=0. It has priority over capture, and no capture occurs. dato_reg and error_bcd are unchanged.
- Segment decode for digits 0..9, in hex: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
  - Nibble > 9 displays a dash, 0x40.
  - Blank is 0x00.
- Outputs per state:
  - REPOSO: anodos=2'b11, segmentos=0x00.
  - MOSTRAR_U: anodos=2'b10, segmentos=decode(units).
  - MOSTRAR_D with tens==0: anodos=2'b11, segmentos=0x00 (leading-zero blank).
  - MOSTRAR_D with tens!=0: anodos=2'b01, segmentos=decode(tens).
- All outputs are decoded only from registered state, cnt, dato_reg and error_bcd. There is no combinational path from any input to any output.

## Timing
- Reset values, asynchronous:
  - state REPOSO, cnt 0, dato_reg 0x00.
  - listo 1, segmentos 0x00, anodos 2'b11, error_bcd 0.
- Reset asserted mid-frame forces these values immediately, without waiting for clk. Operation resumes at the first edge after rst_n deasserts.
- Capture latency: the units digit is lit in the first cycle after the accepting edge.
- Frame length: 2*SCAN_DIV cycles. With a steady source, consecutive words are accepted every 2*SCAN_DIV cycles.
- Each digit is lit for exactly SCAN_DIV cycles. A capture at the frame boundary starts a fresh MOSTRAR_U phase.
- dato_valido rising while listo=0 has no effect until the next listo window. The source must hold the data stable until then.
- apagar and a capture in the same cycle: apagar wins, and listo remains 1 in the following cycle, since the block is now in REPOSO.

## Test plan
- Reset check: pulse rst_n low mid-MOSTRAR_D, between clock edges -> outputs are immediately listo=1, anodos=11, segmentos=00, error_bcd=0.
- Basic scan: capture 0x15 from REPOSO -> next 4 cycles anodos=10, seg=6D; then 4 cycles anodos=01, seg=06; the pattern repeats; error_bcd=0.
- Leading zero: capture 0x07 -> units phase seg=07; tens phase anodos=11, seg=00.
- Invalid BCD and recovery:
  - Capture 0x1A -> error_bcd=1, units phase seg=40, tens phase seg=06.
  - Then hold 0x09 valid -> accepted only in the listo cycle (D phase, cnt=3) -> error_bcd=0.
- Handshake mid-frame: assert dato_valido with 0x12 two cycles into MOSTRAR_U while displaying 0x15 -> listo stays 0 for 5 cycles, pulses for 1 cycle, and 0x12 is displayed from the next cycle.
- Full decoder sweep plus apagar:
  - Feed 0x00..0x09 and 0x10..0x15 -> every digit code matches the decode table.
  - Assert apagar together with a valid word -> next edge REPOSO, old dato_reg kept, word not accepted.
